// File: rtl/core_bus_arbiter.sv
// Purpose: arbitrates instruction fetch and load/store onto one AXI4-Lite master port, one transaction in flight.
// Latency: req to done is 3 cycles for reads and writes with a zero-wait slave; back-to-back grants are possible.
// Backpressure: AXI valids hold until their ready; a requester holds req until its done pulse.
module core_bus_arbiter #(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [2:0] PROT       = 3'b000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_done,
    output logic [31:0]           i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    input  logic [3:0]            d_wstrb,
    output logic                  d_done,
    output logic [31:0]           d_rdata,
    output logic                  d_err,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    output logic [2:0]            m_axi_arprot,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    output logic [2:0]            m_axi_awprot,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AWW  = 3'd3,
        S_B    = 3'd4
    } state_t;

    state_t                  st, st_nxt;
    logic                    last_d, last_d_nxt;
    logic                    cur_d, cur_d_nxt;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_nxt;
    logic [31:0]             wdata_r, wdata_nxt;
    logic [3:0]              wstrb_r, wstrb_nxt;
    logic                    arvalid_r, arvalid_nxt;
    logic                    rready_r, rready_nxt;
    logic                    awvalid_r, awvalid_nxt;
    logic                    wvalid_r, wvalid_nxt;
    logic                    bready_r, bready_nxt;
    logic                    i_done_r, i_done_nxt;
    logic                    d_done_r, d_done_nxt;
    logic                    d_err_r, d_err_nxt;
    logic [31:0]             i_rdata_r, i_rdata_nxt;
    logic [31:0]             d_rdata_r, d_rdata_nxt;
    logic                    req_i, req_d, grant_d, aw_left, w_left;

    // A requester still shows req during its own done cycle, so mask it to avoid a repeat grant.
    assign req_i   = i_req & ~i_done_r;
    assign req_d   = d_req & ~d_done_r;
    assign grant_d = req_d & (~req_i | ~last_d);
    assign aw_left = awvalid_r & ~m_axi_awready;
    assign w_left  = wvalid_r & ~m_axi_wready;

    always_comb begin
        st_nxt      = st;
        last_d_nxt  = last_d;
        cur_d_nxt   = cur_d;
        addr_nxt    = addr_r;
        wdata_nxt   = wdata_r;
        wstrb_nxt   = wstrb_r;
        arvalid_nxt = arvalid_r;
        rready_nxt  = rready_r;
        awvalid_nxt = awvalid_r;
        wvalid_nxt  = wvalid_r;
        bready_nxt  = bready_r;
        i_done_nxt  = 1'b0;
        d_done_nxt  = 1'b0;
        d_err_nxt   = 1'b0;
        i_rdata_nxt = i_rdata_r;
        d_rdata_nxt = d_rdata_r;
        case (st)
            S_IDLE: begin
                if (req_i || req_d) begin
                    cur_d_nxt  = grant_d;
                    last_d_nxt = grant_d;
                    addr_nxt   = grant_d ? d_addr : i_addr;
                    wdata_nxt  = d_wdata;
                    wstrb_nxt  = d_wstrb;
                    if (grant_d && d_we) begin
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        st_nxt      = S_AWW;
                    end else begin
                        arvalid_nxt = 1'b1;
                        st_nxt      = S_AR;
                    end
                end
            end
            S_AR: begin
                if (m_axi_arready) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    st_nxt      = S_R;
                end
            end
            S_R: begin
                if (m_axi_rvalid) begin
                    rready_nxt = 1'b0;
                    st_nxt     = S_IDLE;
                    if (cur_d) begin
                        d_done_nxt  = 1'b1;
                        d_rdata_nxt = m_axi_rdata;
                        d_err_nxt   = |m_axi_rresp;
                    end else begin
                        i_done_nxt  = 1'b1;
                        i_rdata_nxt = m_axi_rdata;
                    end
                end
            end
            S_AWW: begin
                // AW and W complete independently, in either order.
                awvalid_nxt = aw_left;
                wvalid_nxt  = w_left;
                if (!aw_left && !w_left) begin
                    bready_nxt = 1'b1;
                    st_nxt     = S_B;
                end
            end
            S_B: begin
                if (m_axi_bvalid) begin
                    bready_nxt = 1'b0;
                    d_done_nxt = 1'b1;
                    d_err_nxt  = |m_axi_bresp;
                    st_nxt     = S_IDLE;
                end
            end
            default: st_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st        <= S_IDLE;
            last_d    <= 1'b0;
            cur_d     <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= '0;
            wstrb_r   <= '0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            i_done_r  <= 1'b0;
            d_done_r  <= 1'b0;
            d_err_r   <= 1'b0;
            i_rdata_r <= '0;
            d_rdata_r <= '0;
        end else begin
            st        <= st_nxt;
            last_d    <= last_d_nxt;
            cur_d     <= cur_d_nxt;
            addr_r    <= addr_nxt;
            wdata_r   <= wdata_nxt;
            wstrb_r   <= wstrb_nxt;
            arvalid_r <= arvalid_nxt;
            rready_r  <= rready_nxt;
            awvalid_r <= awvalid_nxt;
            wvalid_r  <= wvalid_nxt;
            bready_r  <= bready_nxt;
            i_done_r  <= i_done_nxt;
            d_done_r  <= d_done_nxt;
            d_err_r   <= d_err_nxt;
            i_rdata_r <= i_rdata_nxt;
            d_rdata_r <= d_rdata_nxt;
        end
    end

    assign i_done        = i_done_r;
    assign i_rdata       = i_rdata_r;
    assign d_done        = d_done_r;
    assign d_rdata       = d_rdata_r;
    assign d_err         = d_err_r;
    assign m_axi_araddr  = addr_r;
    assign m_axi_arvalid = arvalid_r;
    assign m_axi_arprot  = PROT;
    assign m_axi_rready  = rready_r;
    assign m_axi_awaddr  = addr_r;
    assign m_axi_awvalid = awvalid_r;
    assign m_axi_awprot  = PROT;
    assign m_axi_wdata   = wdata_r;
    assign m_axi_wstrb   = wstrb_r;
    assign m_axi_wvalid  = wvalid_r;
    assign m_axi_bready  = bready_r;
    assign state         = st;

endmodule
